// File: rtl/f5_rd_ctrl.sv
// Read controller for the 5x5 f5 map: sweeps addresses 0..24 NUM_PASS times and
// streams the returned words through a 2-entry skid FIFO with last/final tags.
module f5_rd_ctrl #(
    parameter int DATA_W   = 16,
    parameter int NUM_PASS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [4:0]        f5_raddr,
    output logic              f5_rd_en,
    input  logic [DATA_W-1:0] f5_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              out_final,
    output logic              busy,
    output logic              done
);

    localparam logic [4:0] LAST_ADDR = 5'd24;
    localparam logic [7:0] LAST_PASS = 8'(NUM_PASS - 1);

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_RUN   = 4'b0010,
        S_DRAIN = 4'b0100,
        S_DONE  = 4'b1000
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [4:0]        addr;
    logic [7:0]        pass;
    logic              end_of_sweep;
    logic              end_of_job;

    logic              vld_p1;
    logic              last_p1;
    logic              final_p1;

    logic [DATA_W-1:0] fifo_data  [2];
    logic              fifo_last  [2];
    logic              fifo_final [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic              push;
    logic              pop;
    logic [2:0]        credit;

    assign end_of_sweep = (addr == LAST_ADDR);
    assign end_of_job   = end_of_sweep && (pass == LAST_PASS);

    assign push = vld_p1;
    assign pop  = out_valid && out_ready;

    // Occupancy counts a transfer leaving this cycle, so a full pipeline
    // (one word in the FIFO, one read in flight) still issues with out_ready high.
    assign credit = {1'b0, count} + {2'b0, vld_p1} - {2'b0, pop};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (f5_rd_en && end_of_job) state_nxt = S_DRAIN;
            S_DRAIN: if ((count == 2'd0) && !vld_p1) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != S_IDLE);
        done     = (state == S_DONE);
        f5_rd_en = (state == S_RUN) && (credit < 3'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
            pass <= '0;
        end else if (f5_rd_en) begin
            addr <= end_of_sweep ? 5'd0 : addr + 5'd1;
            if (end_of_sweep) begin
                pass <= end_of_job ? 8'd0 : pass + 8'd1;
            end
        end
    end

    assign f5_raddr = addr;

    // p1: read in flight, tags travel with it until the data returns
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            last_p1  <= 1'b0;
            final_p1 <= 1'b0;
        end else begin
            vld_p1   <= f5_rd_en;
            last_p1  <= f5_rd_en && end_of_sweep;
            final_p1 <= f5_rd_en && end_of_job;
        end
    end

    // p2: returned word captured into the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data[i]  <= '0;
                fifo_last[i]  <= 1'b0;
                fifo_final[i] <= 1'b0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr]  <= f5_rdata;
                fifo_last[wr_ptr]  <= last_p1;
                fifo_final[wr_ptr] <= final_p1;
                wr_ptr             <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign out_valid = (count != 2'd0);
    assign out_data  = fifo_data[rd_ptr];
    assign out_last  = out_valid && fifo_last[rd_ptr];
    assign out_final = out_valid && fifo_final[rd_ptr];

endmodule

// File: tb/tb_f5_rd_ctrl.sv
// Scoreboard bench for f5_rd_ctrl: one instance with NUM_PASS=1, one with NUM_PASS=2,
// each backed by a 1-cycle-latency buffer model holding base + addr*3.
module tb_f5_rd_ctrl;

    localparam int DW = 16;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic          fin;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start     [2];
    logic [4:0]    raddr     [2];
    logic          rd_en     [2];
    logic [DW-1:0] rdata     [2];
    logic [DW-1:0] out_data  [2];
    logic          out_valid [2];
    logic          out_ready [2];
    logic          out_last  [2];
    logic          out_final [2];
    logic          busy      [2];
    logic          done      [2];
    logic [DW-1:0] base      [2];

    exp_t exp_q [2][$];
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;
    int   rd_total   [2];
    int   xfer_total [2];
    int   last_xfer  [2];
    logic done_exp   [2];
    logic pv [2];
    logic pr [2];
    exp_t pw [2];
    exp_t e;
    logic [26:0] rv;
    int   s_cyc;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : gen_dut
            f5_rd_ctrl #(.DATA_W(DW), .NUM_PASS(g + 1)) dut (
                .clk(clk), .rst_n(rst_n), .start(start[g]),
                .f5_raddr(raddr[g]), .f5_rd_en(rd_en[g]), .f5_rdata(rdata[g]),
                .out_data(out_data[g]), .out_valid(out_valid[g]), .out_ready(out_ready[g]),
                .out_last(out_last[g]), .out_final(out_final[g]),
                .busy(busy[g]), .done(done[g])
            );
            always @(posedge clk) begin
                if (rd_en[g]) rdata[g] <= base[g] + 16'(raddr[g]) * 16'd3;
            end
        end
    endgenerate

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                rv = {raddr[k], rd_en[k], out_valid[k], out_last[k], out_final[k],
                      out_data[k], busy[k], done[k]};
                check("reset_outputs", 32'(rv), 32'd0);
                exp_q[k].delete();
                rd_total[k]   = 0;
                xfer_total[k] = 0;
                pv[k]         = 1'b0;
                pr[k]         = 1'b1;
                done_exp[k]   = 1'b0;
            end else begin
                if (pv[k] && !pr[k])
                    check("stall_hold", 32'({out_valid[k], out_data[k], out_last[k], out_final[k]}),
                          32'({1'b1, pw[k]}));
                if (rd_en[k])
                    check("read_credit",
                          32'((rd_total[k] - xfer_total[k] - int'(out_valid[k] && out_ready[k])) < 2),
                          32'd1);
                if (out_valid[k] && out_ready[k]) begin
                    check("word_expected", 32'(exp_q[k].size() != 0), 32'd1);
                    if (exp_q[k].size() != 0) begin
                        e = exp_q[k].pop_front();
                        check("word", 32'({out_data[k], out_last[k], out_final[k]}), 32'(e));
                    end
                    xfer_total[k]++;
                    last_xfer[k] = cyc;
                end
                if (done[k]) begin
                    check("done_expected", 32'(done_exp[k]), 32'd1);
                    check("done_all_words", 32'(exp_q[k].size()), 32'd0);
                    check("done_timing", 32'(cyc - last_xfer[k]), 32'd2);
                    done_exp[k] = 1'b0;
                end
                rd_total[k] += int'(rd_en[k]);
                pv[k] = out_valid[k];
                pr[k] = out_ready[k];
                pw[k] = {out_data[k], out_last[k], out_final[k]};
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int k, input logic [DW-1:0] b);
        exp_t x;
        base[k] = b;
        for (int p = 0; p <= k; p++) begin
            for (int a = 0; a < 25; a++) begin
                x.data = b + 16'(a * 3);
                x.last = (a == 24);
                x.fin  = (a == 24) && (p == k);
                exp_q[k].push_back(x);
            end
        end
        done_exp[k] = 1'b1;
        start[k]    = 1'b1;
        s_cyc       = cyc;
        tick();
        start[k]    = 1'b0;
    endtask

    task automatic wait_done(input int k, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done[k] && n < 400);
        check(name, 32'(done[k]), 32'd1);
        tick();
        check("idle_after_done", 32'({busy[k], done[k]}), 32'd0);
    endtask

    task automatic wait_first_valid(input int k);
        int n = 0;
        while (!out_valid[k] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("first_valid_latency", 32'(cyc - s_cyc), 32'd3);
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            start[k] = 1'b0; out_ready[k] = 1'b1; base[k] = '0;
        end
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Single pass, back-to-back
        issue(0, 16'd0);
        check("busy_run", 32'(busy[0]), 32'd1);
        wait_first_valid(0);
        wait_done(0, "done_single_pass");

        // Two passes, back-to-back
        issue(1, 16'd1000);
        wait_first_valid(1);
        wait_done(1, "done_two_pass");

        // Two passes, random backpressure
        issue(1, 16'd2000);
        cnt = 0;
        while (!done[1] && cnt < 1000) begin
            out_ready[1] = 1'($urandom_range(0, 1));
            @(negedge clk);
            cnt++;
            if (!done[1]) tick();
        end
        out_ready[1] = 1'b1;
        check("done_random_ready", 32'(done[1]), 32'd1);
        tick();

        // Stalled for 10 cycles after start
        out_ready[0] = 1'b0;
        issue(0, 16'd300);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cnt += int'(rd_en[0]);
        end
        check("stalled_reads", 32'(cnt), 32'd2);
        check("stalled_head", 32'({out_valid[0], out_data[0]}), 32'({1'b1, 16'd300}));
        tick();
        out_ready[0] = 1'b1;
        wait_done(0, "done_after_stall");

        // Second start during RUN is ignored
        issue(0, 16'd500);
        repeat (5) tick();
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        wait_done(0, "done_restart_ignored");
        repeat (30) tick();
        check("no_second_job", 32'(busy[0]), 32'd0);

        // Reset mid-job at word 12, then a fresh sweep
        issue(0, 16'd700);
        cnt = 0;
        while (xfer_total[0] < 12 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check("reached_word12", 32'(xfer_total[0] >= 12), 32'd1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        rv = {raddr[0], rd_en[0], out_valid[0], out_last[0], out_final[0],
              out_data[0], busy[0], done[0]};
        check("async_reset", 32'(rv), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check("aborted_idle", 32'(busy[0]), 32'd0);
        issue(0, 16'd900);
        wait_first_valid(0);
        wait_done(0, "done_after_abort");
        check("fresh_sweep_count", 32'(xfer_total[0]), 32'd25);

        repeat (3) tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/f5_rd_ctrl.md
F5_RD_CTRL -- requirements
Module: f5_rd_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16, f5 word width.
REQ-002 SHALL have parameter NUM_PASS, default 1, full 25-word sweeps per start (1..255).
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle pulse (driven by pool2 done); begins a read job.
REQ-006 f5_raddr  output  5  f5 buffer read address, 0..24 (5x5 map, row-major, addr = row*5+col).
REQ-007 f5_rd_en  output  1  read strobe; buffer returns f5_rdata exactly 1 cycle later.
REQ-008 f5_rdata  input  DATA_W  buffer read data.
REQ-009 out_data  output  DATA_W  stream word.
REQ-010 out_valid  output  1  out_data valid.
REQ-011 out_ready  input  1  downstream accepts; transfer when out_valid && out_ready.
REQ-012 out_last  output  1  marks word of address 24 (end of a sweep).
REQ-013 out_final  output  1  marks word 24 of the last pass (end of job).
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 done  output  1  one-cycle pulse at job completion.

Function
REQ-016 SHALL implement FSM IDLE, RUN, DRAIN, DONE (one-hot encoding).
REQ-017 IDLE->RUN when start=1; start in any other state SHALL be ignored.
REQ-018 RUN SHALL issue reads addr 0,1,...,24, wrap to 0 and increment pass counter; RUN->DRAIN in the cycle after the read of addr 24 of pass NUM_PASS-1 is issued.
REQ-019 DRAIN->DONE when output buffer empty and no read in flight; DONE->IDLE unconditionally next cycle.
REQ-020 done SHALL be high exactly during the DONE-state cycle.
REQ-021 Returned data SHALL enter a 2-entry FIFO; out_data/out_valid/out_last/out_final driven from FIFO head (registered, no combinational path from f5_rdata).
REQ-022 f5_rd_en SHALL assert only if (FIFO occupancy + reads in flight) < 2, so no returned word is ever dropped.
REQ-023 With out_ready held 1, SHALL sustain one read per cycle and one transfer per cycle after initial latency.
REQ-024 Latency start -> first out_valid SHALL be 3 cycles (start sampled, read issued, data captured).
REQ-025 out_data/out_last/out_final SHALL be stable while out_valid=1 and out_ready=0.
REQ-026 Words SHALL emerge in issue order; total transfers per job = 25*NUM_PASS.
REQ-027 out_last/out_final SHALL be tag bits carried alongside each FIFO entry, set at read-issue time.
REQ-028 Address counter 5 bits, wraps 24->0; pass counter 8 bits, wraps to 0 at job end.
REQ-029 f5_raddr SHALL hold last value when f5_rd_en=0; value is don't-care to buffer then.

Reset
REQ-030 On rst_n=0: state IDLE, counters 0, FIFO empty, in-flight flag 0, f5_raddr=0, f5_rd_en=0, out_valid=0, out_last=0, out_final=0, out_data=0, busy=0, done=0.
REQ-031 Reset mid-job SHALL abort immediately; no done pulse; next start begins at addr 0, pass 0.

Verification
REQ-032 NUM_PASS=1, out_ready=1, buffer holds addr*3: start -> out_valid first at cycle 3, 25 back-to-back words 0,3,...,72, out_last=out_final=1 on 72 only, done pulse 1 cycle after final transfer drains.
REQ-033 NUM_PASS=2, out_ready=1: 50 words, out_last on words 25 and 50, out_final only on word 50, single done.
REQ-034 out_ready toggled random (50%): no loss/duplication, data stable while stalled, f5_rd_en never asserted with occupancy+inflight=2.
REQ-035 out_ready=0 for 10 cycles after start: exactly 2 reads issued, out_valid held with word 0, then stream resumes with word 1 unchanged order.
REQ-036 start pulsed again during RUN: ignored, total transfers still 25*NUM_PASS.
REQ-037 rst_n low at word 12: all outputs return to reset values asynchronously, no done; following start yields full fresh sweep from addr 0.
